// File: rtl/rsa_pkg.sv
// rsa_pkg: command codes, sequencer state encoding and settle timing shared by the RSA sequencer
package rsa_pkg;
   typedef enum logic [1:0] {
      CMD_ENCRYPT = 2'b00,
      CMD_LOAD_E  = 2'b01,
      CMD_LOAD_N  = 2'b10,
      CMD_RSVD    = 2'b11
   } cmd_e;
   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_INIT, S_SETTLE, S_CHECK, S_MUL, S_MOD, S_DONE, S_RESP
   } state_e;
   localparam int SETTLE_MIN = 2;
   // The datapath flags lag their strobe by two cycles, so never wait less than that.
   function automatic int settle_cycles(input int s);
      return (s < SETTLE_MIN) ? SETTLE_MIN : s;
   endfunction
endpackage

// File: rtl/rsa_iter_watchdog.sv
// rsa_iter_watchdog: counts MUL passes of one encrypt and flags when the pass limit is reached
module rsa_iter_watchdog #(
   parameter logic [15:0] MAX_ITER = 16'd65535
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);
   logic [15:0] count;
   // pass counter: cleared as an encrypt starts, bumped once per MUL pass
   always_ff @(posedge clk) begin
      if (reset || clr) count <= '0;
      else if (inc) count <= count + 16'd1;
   end
   assign at_limit = (count == MAX_ITER);
endmodule

// File: rtl/rsa_sequencer.sv
// rsa_sequencer: command FSM driving the m^e mod n datapath; RSA_SEQ_PERF_EN adds the perf_cycles latency port
module rsa_sequencer
   import rsa_pkg::*;
#(
   parameter logic [15:0] MAX_ITER = 16'd65535,
   parameter int          SETTLE   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_cmd,
   input  logic [12:0] req_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_err,
   output logic [12:0] dp_data,
   output logic        initialize,
   output logic        en_multiply,
   output logic        en_modulo,
   output logic        done,
   output logic        update_e,
   output logic        update_n,
   input  logic        is_multiplication_done,
   input  logic        is_init_done
`ifdef RSA_SEQ_PERF_EN
   ,output logic [15:0] perf_cycles
`endif
);
   localparam int SETTLE_CYC = settle_cycles(SETTLE);
   localparam int SW = $clog2(SETTLE_CYC);
   state_e state;
   logic [SW-1:0] settle_cnt;
   logic e_zero, n_zero, at_limit;
   assign req_ready = (state == S_IDLE);
   rsa_iter_watchdog #(.MAX_ITER(MAX_ITER)) u_wd (
      .clk      (clk),
      .reset    (reset),
      .clr      (state == S_INIT),
      .inc      (state == S_MUL),
      .at_limit (at_limit)
   );
   // sequencer: strobes are registered with the transition so each is high exactly while in its state
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         settle_cnt  <= '0;
         dp_data     <= '0;
         resp_valid  <= 1'b0;
         resp_err    <= 1'b0;
         e_zero      <= 1'b0;
         n_zero      <= 1'b0;
         initialize  <= 1'b0;
         en_multiply <= 1'b0;
         en_modulo   <= 1'b0;
         done        <= 1'b0;
         update_e    <= 1'b0;
         update_n    <= 1'b0;
      end else begin
         initialize  <= 1'b0;
         en_multiply <= 1'b0;
         en_modulo   <= 1'b0;
         done        <= 1'b0;
         update_e    <= 1'b0;
         update_n    <= 1'b0;
         case (state)
            S_IDLE: if (req_valid) begin
               dp_data <= req_data;
               if (req_cmd == CMD_LOAD_E || req_cmd == CMD_LOAD_N) begin
                  state    <= S_LOAD;
                  update_e <= (req_cmd == CMD_LOAD_E);
                  update_n <= (req_cmd == CMD_LOAD_N);
               end else if (req_cmd == CMD_ENCRYPT && !e_zero && !n_zero) begin
                  state      <= S_INIT;
                  initialize <= 1'b1;
               end else begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end
            end
            S_LOAD: begin
               if (update_e) e_zero <= (dp_data == '0);
               else n_zero <= (dp_data == '0);
               state      <= S_RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
            end
            S_INIT: begin
               settle_cnt <= SW'(SETTLE_CYC - 1);
               state      <= S_SETTLE;
            end
            S_SETTLE: begin
               if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
               else if (!is_init_done) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else state <= S_CHECK;
            end
            S_CHECK: begin
               if (is_multiplication_done) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (at_limit) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else begin
                  state       <= S_MUL;
                  en_multiply <= 1'b1;
               end
            end
            S_MUL: begin
               state     <= S_MOD;
               en_modulo <= 1'b1;
            end
            S_MOD: state <= S_CHECK;
            S_DONE: begin
               state      <= S_RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
            end
            S_RESP: if (resp_ready) begin
               state      <= S_IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
`ifdef RSA_SEQ_PERF_EN
   logic [15:0] perf_cnt;
   logic enc_op;
   // encrypt latency: edges from accept to response, saturating, captured once the response is posted
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_cnt    <= '0;
         perf_cycles <= '0;
         enc_op      <= 1'b0;
      end else if (state == S_IDLE) begin
         perf_cnt <= '0;
         enc_op   <= req_valid && (req_cmd == CMD_ENCRYPT);
      end else if (state == S_RESP) begin
         if (enc_op) perf_cycles <= perf_cnt;
         enc_op <= 1'b0;
      end else perf_cnt <= (perf_cnt == 16'hFFFF) ? perf_cnt : perf_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_rsa_sequencer.sv
// tb_rsa_sequencer: table-driven scoreboard bench with a behavioural datapath model
module tb_rsa_sequencer;
   import rsa_pkg::*;
   typedef struct {
      logic [1:0]  cmd;
      logic [12:0] data;
      bit          err;
      bit          chk_res;
      int          res;
      int          lat;
      int          muls;
      int          inits;
      int          hold;
      int          mb;
      int          ib;
   } vec_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset = 1'b1, req_valid = 1'b0, resp_ready = 1'b0;
   logic [1:0] req_cmd = 2'b00;
   logic [12:0] req_data = '0;
   logic req_ready, resp_valid, resp_err;
   logic [12:0] dp_data;
   logic initialize, en_multiply, en_modulo, done, update_e, update_n;
   logic is_multiplication_done = 1'b0, is_init_done = 1'b0;
   logic [5:0] strobes;
   assign strobes = {initialize, en_multiply, en_modulo, done, update_e, update_n};
   rsa_sequencer dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_data(req_data), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_err(resp_err), .dp_data(dp_data),
      .initialize(initialize), .en_multiply(en_multiply), .en_modulo(en_modulo),
      .done(done), .update_e(update_e), .update_n(update_n),
      .is_multiplication_done(is_multiplication_done), .is_init_done(is_init_done)
   );
   logic w_req_valid = 1'b0, w_resp_ready = 1'b0, w_init_ok = 1'b0;
   logic w_req_ready, w_resp_valid, w_resp_err;
   logic [12:0] w_dp_data;
   logic w_initialize, w_en_multiply, w_en_modulo, w_done, w_update_e, w_update_n;
   rsa_sequencer #(.MAX_ITER(16'd3)) u_wd (
      .clk(clk), .reset(reset), .req_valid(w_req_valid), .req_ready(w_req_ready),
      .req_cmd(2'b00), .req_data(13'd5), .resp_valid(w_resp_valid),
      .resp_ready(w_resp_ready), .resp_err(w_resp_err), .dp_data(w_dp_data),
      .initialize(w_initialize), .en_multiply(w_en_multiply), .en_modulo(w_en_modulo),
      .done(w_done), .update_e(w_update_e), .update_n(w_update_n),
      .is_multiplication_done(1'b0), .is_init_done(w_init_ok)
   );
   // datapath model: e/n survive reset, flags appear two cycles after their strobe
   logic [12:0] dp_e = 13'd17, dp_n = 13'd3233, dp_res = '0;
   logic [7:0] dp_m = '0;
   logic [20:0] dp_prod = '0;
   int dp_cnt = 0;
   logic dp_init = 1'b0;
   always @(posedge clk) begin
      if (update_e) dp_e <= dp_data;
      if (update_n) dp_n <= dp_data;
      if (initialize) begin
         dp_m    <= dp_data[7:0];
         dp_res  <= {5'd0, dp_data[7:0]};
         dp_cnt  <= int'(dp_e) - 1;
         dp_init <= 1'b1;
      end
      if (en_multiply) begin
         dp_prod <= dp_res * dp_m;
         dp_cnt  <= dp_cnt - 1;
      end
      if (en_modulo) dp_res <= 13'(dp_prod % {8'd0, dp_n});
      is_init_done <= dp_init;
      is_multiplication_done <= (dp_cnt == 0);
   end
   int mul_cnt = 0, init_cnt = 0, onehot_bad = 0, w_mul_cnt = 0, w_init_cnt = 0;
   always @(negedge clk) begin
      if (en_multiply) mul_cnt <= mul_cnt + 1;
      if (initialize) init_cnt <= init_cnt + 1;
      if (w_en_multiply) w_mul_cnt <= w_mul_cnt + 1;
      if (w_initialize) w_init_cnt <= w_init_cnt + 1;
      if ($countones(strobes) > 1 ||
          $countones({w_initialize, w_en_multiply, w_en_modulo, w_done, w_update_e, w_update_n}) > 1)
         onehot_bad <= onehot_bad + 1;
   end
   int n_chk = 0, n_fail = 0;
   vec_t sb[$];
   vec_t tbl[14];
   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic int modexp(input int m, input int e, input int n);
      longint r = 1;
      for (int i = 0; i < e; i++) r = (r * m) % n;
      return int'(r);
   endfunction
   function automatic vec_t mk(input logic [1:0] c, input logic [12:0] d, input bit err,
                               input bit cr, input int r, input int lat, input int muls,
                               input int inits, input int hold);
      vec_t v;
      v.cmd = c; v.data = d; v.err = err; v.chk_res = cr; v.res = r; v.lat = lat;
      v.muls = muls; v.inits = inits; v.hold = hold; v.mb = 0; v.ib = 0;
      return v;
   endfunction
   // drive one request from a negedge; returns at the first negedge after the accept edge
   task automatic send(inout vec_t v);
      int n = 0;
      req_cmd = v.cmd; req_data = v.data; req_valid = 1'b1;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      chk("req_ready_wait", req_ready, 1);
      v.mb = mul_cnt; v.ib = init_cnt;
      @(negedge clk);
      req_valid = 1'b0;
   endtask
   task automatic collect();
      vec_t e;
      int lat = 0;
      bit ok = 1'b1;
      while (!resp_valid && lat < 300) begin @(negedge clk); lat++; end
      chk("resp_valid", resp_valid, 1);
      e = sb.pop_front();
      chk("resp_err", resp_err, e.err);
      if (e.chk_res) chk("result", dp_res, e.res);
      if (e.lat >= 0) chk("latency", lat, e.lat);
      chk("mul_pulses", mul_cnt - e.mb, e.muls);
      chk("init_pulses", init_cnt - e.ib, e.inits);
      for (int i = 0; i < e.hold; i++) begin
         @(negedge clk);
         if (!resp_valid || resp_err != e.err || strobes != '0 || req_ready) ok = 1'b0;
      end
      if (e.hold > 0) chk("resp_hold", ok, 1);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_drop", resp_valid, 0);
      chk("idle_ready", req_ready, 1);
   endtask
   task automatic wd_run(input logic init_ok, input int exp_mul, input int exp_init);
      int n = 0;
      int mb = w_mul_cnt, ib = w_init_cnt;
      w_init_ok = init_ok;
      chk("wd_req_ready", w_req_ready, 1);
      w_req_valid = 1'b1;
      @(negedge clk);
      w_req_valid = 1'b0;
      while (!w_resp_valid && n < 300) begin @(negedge clk); n++; end
      chk("wd_resp_valid", w_resp_valid, 1);
      chk("wd_resp_err", w_resp_err, 1);
      chk("wd_mul_pulses", w_mul_cnt - mb, exp_mul);
      chk("wd_init_pulses", w_init_cnt - ib, exp_init);
      w_resp_ready = 1'b1;
      @(negedge clk);
      w_resp_ready = 1'b0;
      chk("wd_resp_drop", w_resp_valid, 0);
   endtask
   initial begin
      vec_t v;
      int n;
      bit quiet;
      tbl[0]  = mk(CMD_ENCRYPT, 13'd65,   0, 1, 2790, 53, 16, 1, 10);
      tbl[1]  = mk(CMD_RSVD,    13'd0,    1, 0, 0,     0,  0, 0, 0);
      tbl[2]  = mk(CMD_LOAD_E,  13'd1,    0, 0, 0,    -1,  0, 0, 0);
      tbl[3]  = mk(CMD_ENCRYPT, 13'd42,   0, 1, 42,    5,  0, 1, 0);
      tbl[4]  = mk(CMD_LOAD_E,  13'd0,    0, 0, 0,    -1,  0, 0, 0);
      tbl[5]  = mk(CMD_ENCRYPT, 13'd7,    1, 0, 0,     0,  0, 0, 0);
      tbl[6]  = mk(CMD_LOAD_E,  13'd3,    0, 0, 0,    -1,  0, 0, 0);
      tbl[7]  = mk(CMD_LOAD_N,  13'd0,    0, 0, 0,    -1,  0, 0, 0);
      tbl[8]  = mk(CMD_ENCRYPT, 13'd9,    1, 0, 0,     0,  0, 0, 0);
      tbl[9]  = mk(CMD_LOAD_N,  13'd3233, 0, 0, 0,    -1,  0, 0, 0);
      tbl[10] = mk(CMD_ENCRYPT, 13'd123,  0, 1, modexp(123, 3, 3233), 11, 2, 1, 0);
      tbl[11] = mk(CMD_LOAD_E,  13'd17,   0, 0, 0,    -1,  0, 0, 0);
      tbl[12] = mk(CMD_ENCRYPT, 13'd65,   0, 1, 2790, 53, 16, 1, 0);
      tbl[13] = mk(CMD_ENCRYPT, 13'd200,  0, 1, modexp(200, 17, 3233), 53, 16, 1, 0);
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_dp_data", dp_data, 0);
      chk("rst_strobes", strobes, 0);
      chk("rst_wd_ready", w_req_ready, 1);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         v = tbl[i];
         send(v);
         sb.push_back(v);
         collect();
      end
      v = mk(CMD_ENCRYPT, 13'd65, 0, 1, 2790, 53, 16, 1, 0);
      send(v);
      n = 0;
      while (!en_multiply && n < 100) begin @(negedge clk); n++; end
      chk("mul_reached", en_multiply, 1);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_strobes", strobes, 0);
      chk("midrst_resp_valid", resp_valid, 0);
      reset = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (resp_valid || strobes != '0 || !req_ready) quiet = 1'b0;
      end
      chk("midrst_quiet", quiet, 1);
      send(v);
      sb.push_back(v);
      collect();
      wd_run(1'b0, 0, 1);
      wd_run(1'b1, 3, 1);
      chk("strobe_onehot", onehot_bad, 0);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
